// File: rtl/pulse_burst_pkg.sv
// Shared types and constants for the pulse burst transmitter.
// MARK_PHASE must match the receiver's state encoding (A..D = 0..3).
package pulse_burst_pkg;

  localparam int PHASE_W = 2;
  localparam logic [PHASE_W-1:0] MARK_PHASE = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } burst_state_e;

  function automatic logic isMarkPhase(input logic [PHASE_W-1:0] phase);
    return phase == MARK_PHASE;
  endfunction

endpackage

// File: rtl/pulse_burst_tx_timer.sv
// Loadable gap down-counter; expired_o flags the last low cycle of a gap.
module pulse_gap_timer #(
  parameter int GAP_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [GAP_W-1:0] loadValue_i,
  input  logic             tick_i,
  output logic             expired_o
);

  logic [GAP_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = loadValue_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - GAP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Loaded with the gap length, so a value of 1 means this is the final gap cycle.
  assign expired_o = (count_q <= GAP_W'(1));

endmodule

// File: rtl/pulse_burst_tx.sv
// Burst pulse transmitter: emits req_count one-cycle pulses separated by req_gap
// low cycles, marking every pulse whose mod-4 group phase is MARK_PHASE.
module pulse_burst_tx
  import pulse_burst_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int GAP_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_count,
  input  logic [GAP_W-1:0] req_gap,
  input  logic             sync_clr,
  output logic             x_out,
  output logic             group_mark,
  output logic             busy,
  output logic             done
);

  burst_state_e state_q, state_d;

  logic [CNT_W-1:0]   pulseLeft_q, pulseLeft_d;
  logic [GAP_W-1:0]   gapLen_q, gapLen_d;
  logic [PHASE_W-1:0] phase_q, phase_d;

  logic reqReady_q, xOut_q, groupMark_q, busy_q, done_q;
  logic reqReady_d, xOut_d, groupMark_d, busy_d, done_d;

  logic accept;
  logic gapExpired;

  assign accept = req_valid & reqReady_q;

  pulse_gap_timer #(
    .GAP_W(GAP_W)
  ) u_gapTimer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (state_q == PULSE),
    .loadValue_i(gapLen_q),
    .tick_i     (state_q == GAP),
    .expired_o  (gapExpired)
  );

  always_comb begin
    state_d     = state_q;
    pulseLeft_d = pulseLeft_q;
    gapLen_d    = gapLen_q;
    phase_d     = phase_q;

    unique case (state_q)
      IDLE: begin
        // A clear in the accept cycle applies first, so the burst starts at phase 0.
        if (sync_clr) begin
          phase_d = '0;
        end
        if (accept) begin
          pulseLeft_d = req_count;
          gapLen_d    = req_gap;
          state_d     = (req_count == '0) ? DONE : PULSE;
        end
      end
      PULSE: begin
        phase_d     = phase_q + PHASE_W'(1);
        pulseLeft_d = pulseLeft_q - CNT_W'(1);
        if (pulseLeft_q == CNT_W'(1)) begin
          state_d = DONE;
        end else if (gapLen_q == '0) begin
          state_d = PULSE;
        end else begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (gapExpired) begin
          state_d = PULSE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state, so they line up with the state itself.
  always_comb begin
    reqReady_d  = (state_d == IDLE);
    xOut_d      = (state_d == PULSE);
    groupMark_d = (state_d == PULSE) && isMarkPhase(phase_d);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pulseLeft_q <= '0;
      gapLen_q    <= '0;
      phase_q     <= '0;
    end else begin
      state_q     <= state_d;
      pulseLeft_q <= pulseLeft_d;
      gapLen_q    <= gapLen_d;
      phase_q     <= phase_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reqReady_q  <= 1'b0;
      xOut_q      <= 1'b0;
      groupMark_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      reqReady_q  <= reqReady_d;
      xOut_q      <= xOut_d;
      groupMark_q <= groupMark_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign req_ready  = reqReady_q;
  assign x_out      = xOut_q;
  assign group_mark = groupMark_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pulse_burst_tx.sv
// Randomized self-checking bench for pulse_burst_tx against a burst-level
// reference model and a behavioural downstream mod-4 pulse counter.
module tb_pulse_burst_tx;

  localparam int CNT_W = 4;
  localparam int GAP_W = 3;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [CNT_W-1:0] req_count;
  logic [GAP_W-1:0] req_gap;
  logic             sync_clr;
  logic             x_out;
  logic             group_mark;
  logic             busy;
  logic             done;

  int checkCount = 0;
  int failCount  = 0;
  int phase      = 0;

  logic       rxClr;
  logic [1:0] rxState;
  logic       rxZ;

  pulse_burst_tx #(
    .CNT_W(CNT_W),
    .GAP_W(GAP_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_count (req_count),
    .req_gap   (req_gap),
    .sync_clr  (sync_clr),
    .x_out     (x_out),
    .group_mark(group_mark),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Downstream Mealy receiver: counts pulses mod 4, z on the 4th of each group.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxState <= 2'd0;
    end else if (rxClr) begin
      rxState <= 2'd0;
    end else if (x_out) begin
      rxState <= rxState + 2'd1;
    end
  end

  assign rxZ = x_out && (rxState == 2'd3);

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("rxZ", rxZ, group_mark);
    end
  end

  task automatic checkQuiet(input string tag);
    checkOutput({tag, ".ready"}, req_ready, 0);
    checkOutput({tag, ".x"}, x_out, 0);
    checkOutput({tag, ".mark"}, group_mark, 0);
    checkOutput({tag, ".busy"}, busy, 0);
    checkOutput({tag, ".done"}, done, 0);
  endtask

  task automatic idleCycles(input int n, input bit clr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("idle.ready", req_ready, 1);
      checkOutput("idle.x", x_out, 0);
      req_valid = 1'b0;
      sync_clr  = clr;
      rxClr     = clr;
    end
    @(negedge clk);
    sync_clr = 1'b0;
    rxClr    = 1'b0;
    if (clr) phase = 0;
  endtask

  task automatic waitReady(output bit ok);
    int waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    ok = req_ready;
    if (!ok) checkOutput("readyTimeout", 0, 1);
  endtask

  task automatic applyStimulus(input int n, input int gap, input bit clr);
    bit ok;
    int phase0;
    int len;
    int k;
    bit expX;
    bit expMark;
    waitReady(ok);
    if (!ok) return;
    req_valid = 1'b1;
    req_count = CNT_W'(n);
    req_gap   = GAP_W'(gap);
    sync_clr  = clr;
    rxClr     = clr;
    phase0    = clr ? 0 : phase;
    len       = (n == 0) ? 2 : n + (n - 1) * gap + 2;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_count = CNT_W'($urandom);
    req_gap   = GAP_W'($urandom);
    sync_clr  = 1'b0;
    rxClr     = 1'b0;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      k       = (c - 1) / (gap + 1) + 1;
      expX    = (n > 0) && ((c - 1) % (gap + 1) == 0) && (k <= n);
      expMark = expX && (((phase0 + k - 1) % 4) == 3);
      checkOutput("x_out", x_out, expX);
      checkOutput("group_mark", group_mark, expMark);
      checkOutput("done", done, c == len - 1);
      checkOutput("busy", busy, c <= len - 1);
      checkOutput("req_ready", req_ready, c == len);
      if (c < len) begin
        req_valid = $urandom_range(0, 1);
        sync_clr  = $urandom_range(0, 1);
        req_count = CNT_W'($urandom);
        req_gap   = GAP_W'($urandom);
      end else begin
        req_valid = 1'b0;
        sync_clr  = 1'b0;
      end
    end
    phase = (phase0 + n) % 4;
  endtask

  initial begin
    bit ok;
    int resetPhase0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_count = '0;
    req_gap   = '0;
    sync_clr  = 1'b0;
    rxClr     = 1'b0;

    repeat (3) begin
      @(negedge clk);
      checkQuiet("reset");
    end
    rst_n = 1'b1;
    #1;
    checkOutput("readyBeforeEdge", req_ready, 0);
    @(negedge clk);
    checkOutput("readyAfterRelease", req_ready, 1);

    applyStimulus(5, 0, 1'b0);
    applyStimulus(3, 2, 1'b0);
    idleCycles(1, 1'b1);
    applyStimulus(3, 1, 1'b0);
    applyStimulus(3, 0, 1'b0);
    applyStimulus(3, 0, 1'b1);
    applyStimulus(3, 0, 1'b0);
    applyStimulus(0, 3, 1'b0);
    applyStimulus(2, 0, 1'b0);

    // Reset in the middle of a count=7, gap=1 burst, right after pulse 2.
    waitReady(ok);
    if (ok) begin
      resetPhase0 = phase;
      req_valid = 1'b1;
      req_count = CNT_W'(7);
      req_gap   = GAP_W'(1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        checkOutput("midX", x_out, (c != 2));
        checkOutput("midMark", group_mark, (c != 2) && (((resetPhase0 + (c - 1) / 2) % 4) == 3));
        checkOutput("midBusy", busy, 1);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checkQuiet("asyncReset");
      repeat (2) begin
        @(negedge clk);
        checkOutput("resetNoDone", done, 0);
        checkOutput("resetNoBusy", busy, 0);
      end
      rst_n = 1'b1;
      phase = 0;
      @(negedge clk);
      checkOutput("readyAfterMidReset", req_ready, 1);
    end
    applyStimulus(4, $urandom_range(0, 3), 1'b0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) idleCycles(2, 1'b1);
      applyStimulus($urandom_range(0, 15), $urandom_range(0, 7), ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
